// File: rtl/des_pkg.sv
// Shared DES constants and types for the key schedule, round and S-box stages.
// Tables use FIPS 46 1-based bit numbers, where bit 1 is the MSB.
package des_pkg;

  typedef logic [63:0] des_key_t;
  typedef logic [27:0] des_half_t;
  typedef logic [47:0] des_subkey_t;

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_RUN  = 1'b1
  } ks_state_t;

  localparam int PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [55:0] pc1(input des_key_t key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1_TABLE[i])];
    end
    return cd;
  endfunction

  function automatic des_half_t rotl(input des_half_t h, input logic [1:0] s);
    return (s == 2'd2) ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction

  function automatic des_half_t rotr(input des_half_t h, input logic [1:0] s);
    return (s == 2'd2) ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction

  // Every byte must carry an odd number of ones.
  function automatic logic odd_parity_ok(input des_key_t key);
    logic       ok;
    logic [7:0] by;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      by = 8'(key >> (8 * b));
      ok = ok & (^by);
    end
    return ok;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC2 permutation: 56-bit {C,D} to a 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0]  cd,
  output des_subkey_t  subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) begin
      subkey[6'(47 - i)] = cd[6'(56 - PC2_TABLE[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key scheduler: emits K1..K16 (or K16..K1 when decrypting)
// one subkey per valid/ready handshake.
module des_key_schedule
  import des_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_load,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        abort,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  ks_state_t   state, state_next;
  des_half_t   c_q, d_q, c_n, d_n;
  logic [3:0]  idx_q, idx_n;
  logic        dec_q, dec_n;
  logic        done_q, done_n;
  logic        perr_q, perr_n;
  logic [55:0] cd0;
  logic        parity_bad;

  assign cd0        = pc1(key_in);
  assign parity_bad = CHECK_PARITY && !odd_parity_ok(key_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= KS_IDLE;
      c_q    <= '0;
      d_q    <= '0;
      idx_q  <= '0;
      dec_q  <= 1'b0;
      done_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state  <= state_next;
      c_q    <= c_n;
      d_q    <= d_n;
      idx_q  <= idx_n;
      dec_q  <= dec_n;
      done_q <= done_n;
      perr_q <= perr_n;
    end
  end

  // Decrypt starts at C16/D16, which equal C0/D0 because the shifts sum to 28;
  // stepping backwards undoes round (16 - idx)'s shift with a right rotate.
  always_comb begin
    state_next = state;
    c_n        = c_q;
    d_n        = d_q;
    idx_n      = idx_q;
    dec_n      = dec_q;
    done_n     = 1'b0;
    perr_n     = 1'b0;
    case (state)
      KS_IDLE: begin
        if (key_load && !abort) begin
          if (parity_bad) begin
            perr_n = 1'b1;
          end else begin
            c_n        = decrypt ? cd0[55:28] : rotl(cd0[55:28], 2'd1);
            d_n        = decrypt ? cd0[27:0]  : rotl(cd0[27:0], 2'd1);
            dec_n      = decrypt;
            idx_n      = '0;
            state_next = KS_RUN;
          end
        end
      end
      KS_RUN: begin
        if (abort) begin
          idx_n      = '0;
          state_next = KS_IDLE;
        end else if (subkey_ready) begin
          if (idx_q == 4'd15) begin
            idx_n      = '0;
            done_n     = 1'b1;
            state_next = KS_IDLE;
          end else if (dec_q) begin
            c_n   = rotr(c_q, 2'(SHIFTS[4'd15 - idx_q]));
            d_n   = rotr(d_q, 2'(SHIFTS[4'd15 - idx_q]));
            idx_n = idx_q + 4'd1;
          end else begin
            c_n   = rotl(c_q, 2'(SHIFTS[idx_q + 4'd1]));
            d_n   = rotl(d_q, 2'(SHIFTS[idx_q + 4'd1]));
            idx_n = idx_q + 4'd1;
          end
        end
      end
      default: state_next = KS_IDLE;
    endcase
  end

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey)
  );

  assign subkey_valid = (state == KS_RUN);
  assign busy         = (state == KS_RUN);
  assign round_idx    = idx_q;
  assign done         = done_q;
  assign parity_err   = perr_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a cumulative-rotation DES key model.
module tb_des_key_schedule;

  localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BADP = 64'h133457799BBCDFF0;

  localparam int REF_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int REF_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int REF_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk, rst_n, key_load, key_load_p, decrypt, abort, subkey_ready;
  logic [63:0] key_in;
  logic        valid, busy, done, perr;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        p_valid, p_busy, p_done, p_perr;
  logic [47:0] p_subkey;
  logic [3:0]  p_round_idx;

  logic [47:0] exp_ks [16];
  logic [47:0] got_ks [16];
  logic [47:0] enc_ks [16];
  int checks = 0;
  int fails  = 0;

  des_key_schedule #(.CHECK_PARITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in), .decrypt(decrypt),
    .abort(abort), .subkey_valid(valid), .subkey_ready(subkey_ready), .subkey(subkey),
    .round_idx(round_idx), .busy(busy), .done(done), .parity_err(perr)
  );

  des_key_schedule #(.CHECK_PARITY(1'b1)) dutp (
    .clk(clk), .rst_n(rst_n), .key_load(key_load_p), .key_in(key_in), .decrypt(decrypt),
    .abort(abort), .subkey_valid(p_valid), .subkey_ready(subkey_ready), .subkey(p_subkey),
    .round_idx(p_round_idx), .busy(p_busy), .done(p_done), .parity_err(p_perr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Round r uses C0/D0 rotated left by the running shift total; decrypt just reverses order.
  function automatic void build_model(input logic [63:0] key, input bit dec);
    logic [55:0] cd0, cdr, t56;
    logic [63:0] t64;
    logic [27:0] c, d;
    logic [47:0] k;
    int tot;
    cd0 = '0;
    for (int j = 0; j < 56; j++) begin
      t64 = key >> (64 - REF_PC1[j]);
      cd0 = {cd0[54:0], t64[0]};
    end
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot = (tot + REF_SHIFTS[r]) % 28;
      c = cd0[55:28];
      d = cd0[27:0];
      c = (c << tot) | (c >> (28 - tot));
      d = (d << tot) | (d >> (28 - tot));
      cdr = {c, d};
      k = '0;
      for (int i = 0; i < 48; i++) begin
        t56 = cdr >> (56 - REF_PC2[i]);
        k = {k[46:0], t56[0]};
      end
      if (dec) exp_ks[15 - r] = k;
      else     exp_ks[r] = k;
    end
  endfunction

  task automatic start(input logic [63:0] k, input bit dec);
    @(negedge clk);
    key_in = k;
    decrypt = dec;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  // Drives ready with pct% probability and checks each offered subkey against exp_ks.
  task automatic collect(input int pct, input int load_at, input int abort_at,
                         input bit chain, input logic [63:0] chain_key,
                         output int nacc, output int cycles);
    logic [47:0] prev_k;
    logic [3:0]  prev_i;
    bit stalled, fin;
    int guard;
    stalled = 0; fin = 0; guard = 0; nacc = 0; cycles = 0;
    prev_k = '0; prev_i = '0;
    while (!fin && guard < 2000) begin
      @(negedge clk);
      guard++;
      key_load = 1'b0;
      abort = 1'b0;
      if (stalled) begin
        checks++;
        if (subkey !== prev_k || round_idx !== prev_i || valid !== 1'b1) begin
          fails++;
          $display("[TB] FAIL stall_hold: got key=%h idx=%0d valid=%b required key=%h idx=%0d valid=1",
                   subkey, round_idx, valid, prev_k, prev_i);
        end
      end
      stalled = 0;
      subkey_ready = 1'b0;
      if (valid === 1'b1) begin
        cycles++;
        checks++;
        if (round_idx !== 4'(nacc)) begin
          fails++;
          $display("[TB] FAIL round_idx: got %0d required %0d", round_idx, nacc);
        end
        checks++;
        if (subkey !== exp_ks[nacc]) begin
          fails++;
          $display("[TB] FAIL subkey[%0d]: got %h required %h", nacc, subkey, exp_ks[nacc]);
        end
        checks++;
        if (done !== 1'b0) begin
          fails++;
          $display("[TB] FAIL early_done: got %b required 0", done);
        end
        got_ks[nacc] = subkey;
        if (nacc == abort_at) begin
          abort = 1'b1;
          subkey_ready = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          subkey_ready = 1'b0;
          checks++;
          if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_drop: got valid=%b busy=%b done=%b required 0 0 0", valid, busy, done);
          end
          @(negedge clk);
          checks++;
          if (done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_nodone: got %b required 0", done);
          end
          fin = 1;
        end else begin
          if (nacc == load_at) begin
            key_load = 1'b1;
            key_in = ~key_in;
            decrypt = ~decrypt;
          end
          if ($urandom_range(99) < pct) begin
            subkey_ready = 1'b1;
            nacc++;
          end else begin
            stalled = 1;
            prev_k = subkey;
            prev_i = round_idx;
          end
          if (nacc == 16) begin
            @(negedge clk);
            subkey_ready = 1'b0;
            key_load = 1'b0;
            checks++;
            if (done !== 1'b1 || valid !== 1'b0) begin
              fails++;
              $display("[TB] FAIL done_pulse: got done=%b valid=%b required done=1 valid=0", done, valid);
            end
            if (chain) begin
              key_in = chain_key;
              decrypt = 1'b0;
              key_load = 1'b1;
            end
            @(negedge clk);
            key_load = 1'b0;
            checks++;
            if (done !== 1'b0) begin
              fails++;
              $display("[TB] FAIL done_width: got %b required 0", done);
            end
            fin = 1;
          end
        end
      end
    end
    if (!fin) begin
      checks++;
      fails++;
      $display("[TB] FAIL timeout: got %0d accepts required 16 within budget", nacc);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({valid, busy, done, perr, round_idx} !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b required 00000000", {valid, busy, done, perr, round_idx});
    end
    checks++;
    if (subkey !== 48'h0) begin
      fails++;
      $display("[TB] FAIL reset_subkey: got %h required 0", subkey);
    end
    checks++;
    if ({p_valid, p_busy, p_done, p_perr} !== 4'h0) begin
      fails++;
      $display("[TB] FAIL reset_parity_inst: got %b required 0000", {p_valid, p_busy, p_done, p_perr});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt();
    int n, cyc;
    build_model(KEY_GOOD, 1'b0);
    @(negedge clk);
    key_in = KEY_GOOD;
    decrypt = 1'b0;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    checks++;
    if (valid !== 1'b1 || round_idx !== 4'd0 || subkey !== 48'h1B02EFFC7072) begin
      fails++;
      $display("[TB] FAIL enc_latency: got valid=%b idx=%0d key=%h required 1 0 1b02effc7072", valid, round_idx, subkey);
    end
    collect(100, -1, -1, 1'b0, 64'h0, n, cyc);
    checks++;
    if (cyc !== 16) begin
      fails++;
      $display("[TB] FAIL enc_valid_cycles: got %0d required 16", cyc);
    end
    checks++;
    if (got_ks[1] !== 48'h79AED9DBC9E5 || got_ks[15] !== 48'hCB3D8B0E17F5) begin
      fails++;
      $display("[TB] FAIL enc_kat: got K2=%h K16=%h required 79aed9dbc9e5 cb3d8b0e17f5", got_ks[1], got_ks[15]);
    end
    enc_ks = got_ks;
  endtask

  task automatic test_decrypt();
    int n, cyc;
    build_model(KEY_GOOD, 1'b1);
    start(KEY_GOOD, 1'b1);
    collect(100, -1, -1, 1'b0, 64'h0, n, cyc);
    checks++;
    if (got_ks[0] !== 48'hCB3D8B0E17F5 || got_ks[15] !== 48'h1B02EFFC7072) begin
      fails++;
      $display("[TB] FAIL dec_kat: got first=%h last=%h required cb3d8b0e17f5 1b02effc7072", got_ks[0], got_ks[15]);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got_ks[i] !== enc_ks[15 - i]) begin
        fails++;
        $display("[TB] FAIL dec_reversed[%0d]: got %h required %h", i, got_ks[i], enc_ks[15 - i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n, cyc;
    logic [63:0] k;
    bit dec;
    for (int it = 0; it < 3; it++) begin
      k = {$urandom, $urandom};
      dec = 1'($urandom_range(1));
      build_model(k, dec);
      start(k, dec);
      collect(30, -1, -1, 1'b0, 64'h0, n, cyc);
      checks++;
      if (n !== 16) begin
        fails++;
        $display("[TB] FAIL bp_accepts: got %0d required 16", n);
      end
    end
  endtask

  task automatic test_load_while_busy();
    int n, cyc;
    build_model(KEY_GOOD, 1'b0);
    start(KEY_GOOD, 1'b0);
    collect(70, 4, -1, 1'b0, 64'h0, n, cyc);
    checks++;
    if (n !== 16) begin
      fails++;
      $display("[TB] FAIL busy_load_accepts: got %0d required 16", n);
    end
  endtask

  task automatic test_abort();
    int n, cyc;
    build_model(KEY_GOOD, 1'b0);
    start(KEY_GOOD, 1'b0);
    collect(100, -1, 7, 1'b0, 64'h0, n, cyc);
    checks++;
    if (n !== 7) begin
      fails++;
      $display("[TB] FAIL abort_point: got %0d accepts required 7", n);
    end
    start(KEY_GOOD, 1'b0);
    collect(100, -1, -1, 1'b0, 64'h0, n, cyc);
    checks++;
    if (got_ks[0] !== 48'h1B02EFFC7072 || n !== 16) begin
      fails++;
      $display("[TB] FAIL abort_reload: got K1=%h n=%0d required 1b02effc7072 16", got_ks[0], n);
    end
  endtask

  task automatic test_back_to_back();
    int n, cyc;
    logic [63:0] k2;
    k2 = {$urandom, $urandom};
    build_model(KEY_GOOD, 1'b0);
    start(KEY_GOOD, 1'b0);
    collect(100, -1, -1, 1'b1, k2, n, cyc);
    build_model(k2, 1'b0);
    collect(100, -1, -1, 1'b0, 64'h0, n, cyc);
    checks++;
    if (n !== 16) begin
      fails++;
      $display("[TB] FAIL b2b_accepts: got %0d required 16", n);
    end
  endtask

  task automatic test_parity();
    int n, cyc;
    @(negedge clk);
    key_in = KEY_BADP;
    decrypt = 1'b0;
    key_load_p = 1'b1;
    @(negedge clk);
    key_load_p = 1'b0;
    checks++;
    if (p_perr !== 1'b1 || p_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL parity_reject: got perr=%b busy=%b required 1 0", p_perr, p_busy);
    end
    @(negedge clk);
    checks++;
    if (p_perr !== 1'b0 || p_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL parity_pulse: got perr=%b busy=%b required 0 0", p_perr, p_busy);
    end
    key_in = KEY_GOOD;
    key_load_p = 1'b1;
    @(negedge clk);
    key_load_p = 1'b0;
    checks++;
    if (p_busy !== 1'b1 || p_perr !== 1'b0 || p_subkey !== 48'h1B02EFFC7072) begin
      fails++;
      $display("[TB] FAIL parity_accept: got busy=%b perr=%b key=%h required 1 0 1b02effc7072", p_busy, p_perr, p_subkey);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    build_model(KEY_GOOD, 1'b0);
    start(KEY_BADP, 1'b0);
    checks++;
    if (perr !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL noparity_accept: got perr=%b busy=%b required 0 1", perr, busy);
    end
    collect(100, -1, -1, 1'b0, 64'h0, n, cyc);
  endtask

  task automatic test_async_reset();
    int ncut;
    logic [63:0] k;
    k = {$urandom, $urandom};
    ncut = $urandom_range(2, 13);
    start(k, 1'b0);
    for (int i = 0; i < ncut; i++) begin
      @(negedge clk);
      subkey_ready = 1'b1;
    end
    @(negedge clk);
    subkey_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, busy, done, perr, round_idx} !== 8'h00 || subkey !== 48'h0) begin
      fails++;
      $display("[TB] FAIL async_reset: got ctrl=%b key=%h required 00000000 0",
               {valid, busy, done, perr, round_idx}, subkey);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish required finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    key_load = 1'b0;
    key_load_p = 1'b0;
    key_in = '0;
    decrypt = 1'b0;
    abort = 1'b0;
    subkey_ready = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_load_while_busy();
    test_abort();
    test_back_to_back();
    test_parity();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
